// File: rtl/acq_trigger_sequencer.sv
// Acquisition trigger/stop sequencer: edge-detected event sources combined per phase into
// start/stop matches, with optional arm gate, start-wait timeout and latched stop cause.
module acq_trigger_sequencer #(
    parameter int unsigned NUM_EVT = 4,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TMO_W   = 16
) (
    input  logic               clk_master,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [NUM_EVT-1:0] evt_in,
    input  logic [NUM_EVT-1:0] start_mask,
    input  logic [NUM_EVT-1:0] stop_mask,
    input  logic               start_all,
    input  logic               stop_all,
    input  logic [CNT_W-1:0]   start_num,
    input  logic [CNT_W-1:0]   stop_num,
    input  logic               gate_en,
    input  logic               arm_gate,
    input  logic               mem_full,
    input  logic               tick,
    input  logic [TMO_W-1:0]   timeout,
    output logic               waiting,
    output logic               acquiring,
    output logic               done,
    output logic [1:0]         stop_cause
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StGate = 2'd1;
    localparam logic [1:0] StWait = 2'd2;
    localparam logic [1:0] StAcq  = 2'd3;

    localparam logic [1:0] CauseEvt   = 2'b00;
    localparam logic [1:0] CauseFull  = 2'b01;
    localparam logic [1:0] CauseTmo   = 2'b10;
    localparam logic [1:0] CauseAbort = 2'b11;

    logic [1:0]         state_q, state_d;
    logic [NUM_EVT-1:0] evt_prev_q;
    logic [NUM_EVT-1:0] seen_q, seen_d;
    logic [CNT_W-1:0]   scnt_q, scnt_d;
    logic [CNT_W-1:0]   ecnt_q, ecnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [TMO_W-1:0]   tmo_inc;
    logic [1:0]         cause_q, cause_d;
    logic               done_q, done_d;

    logic [NUM_EVT-1:0] rise;
    logic [NUM_EVT-1:0] phase_mask;
    logic [NUM_EVT-1:0] rise_m;
    logic               phase_all;
    logic               match;

    // The stop phase uses the stop configuration; every other state the start configuration.
    always_comb begin
        rise       = evt_in & ~evt_prev_q;
        phase_mask = (state_q == StAcq) ? stop_mask : start_mask;
        phase_all  = (state_q == StAcq) ? stop_all : start_all;
        rise_m     = rise & phase_mask;
        if (phase_mask == '0) begin
            match = 1'b1;
        end else if (phase_all) begin
            match = &(seen_q | rise_m | ~phase_mask);
        end else begin
            match = |rise_m;
        end
    end

    assign tmo_inc = tmo_q + 1'b1;

    always_comb begin
        state_d = state_q;
        seen_d  = '0;
        scnt_d  = scnt_q;
        ecnt_d  = ecnt_q;
        tmo_d   = tmo_q;
        cause_d = cause_q;

        if (state_q != StIdle && abort) begin
            state_d = StIdle;
            cause_d = CauseAbort;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        scnt_d  = start_num;
                        ecnt_d  = stop_num;
                        tmo_d   = '0;
                        cause_d = CauseEvt;
                        state_d = gate_en ? StGate : StWait;
                    end
                end
                StGate: begin
                    if (arm_gate) begin
                        state_d = StWait;
                    end
                end
                StWait: begin
                    if (match) begin
                        if (scnt_q != '0) begin
                            scnt_d = scnt_q - 1'b1;
                        end else begin
                            state_d = StAcq;
                        end
                    end else begin
                        if (phase_all) begin
                            seen_d = seen_q | rise_m;
                        end
                        if (tick && timeout != '0) begin
                            tmo_d = tmo_inc;
                            if (tmo_inc == timeout) begin
                                state_d = StIdle;
                                cause_d = CauseTmo;
                            end
                        end
                    end
                end
                default: begin
                    if (mem_full) begin
                        state_d = StIdle;
                        cause_d = CauseFull;
                    end else if (match) begin
                        if (ecnt_q != '0) begin
                            ecnt_d = ecnt_q - 1'b1;
                        end else begin
                            state_d = StIdle;
                            cause_d = CauseEvt;
                        end
                    end else if (phase_all) begin
                        seen_d = seen_q | rise_m;
                    end
                end
            endcase
        end

        done_d = (state_q != StIdle) && (state_d == StIdle);
    end

    // Previous-level register resets to all-ones so a level already high is not an event.
    always_ff @(posedge clk_master or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            evt_prev_q <= '1;
            seen_q     <= '0;
            scnt_q     <= '0;
            ecnt_q     <= '0;
            tmo_q      <= '0;
            cause_q    <= CauseEvt;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            evt_prev_q <= evt_in;
            seen_q     <= seen_d;
            scnt_q     <= scnt_d;
            ecnt_q     <= ecnt_d;
            tmo_q      <= tmo_d;
            cause_q    <= cause_d;
            done_q     <= done_d;
        end
    end

    assign waiting    = (state_q == StGate) || (state_q == StWait);
    assign acquiring  = (state_q == StAcq);
    assign done       = done_q;
    assign stop_cause = cause_q;

endmodule

// File: tb/tb_acq_trigger_sequencer.sv
// Bench for acq_trigger_sequencer: vector table, directed corner sequences, and random
// stimulus against a match-counting reference model.
module tb_acq_trigger_sequencer;

    logic        clk_master = 1'b0;
    logic        reset_n;
    logic        start, abort, start_all, stop_all, gate_en, arm_gate, mem_full, tick;
    logic [3:0]  evt_in, start_mask, stop_mask;
    logic [7:0]  start_num, stop_num;
    logic [15:0] timeout;
    logic        waiting, acquiring, done;
    logic [1:0]  stop_cause;

    acq_trigger_sequencer #(.NUM_EVT(4), .CNT_W(8), .TMO_W(16)) dut (
        .clk_master(clk_master), .reset_n(reset_n), .start(start), .abort(abort),
        .evt_in(evt_in), .start_mask(start_mask), .stop_mask(stop_mask),
        .start_all(start_all), .stop_all(stop_all), .start_num(start_num),
        .stop_num(stop_num), .gate_en(gate_en), .arm_gate(arm_gate), .mem_full(mem_full),
        .tick(tick), .timeout(timeout), .waiting(waiting), .acquiring(acquiring),
        .done(done), .stop_cause(stop_cause)
    );

    always #5 clk_master = ~clk_master;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_model = 1'b0;

    // Reference model: phase 0 idle, 1 gate, 2 wait, 3 acquire; counts matches up to n+1.
    bit [3:0] m_prev, m_seen;
    int       m_phase, m_got, m_need_s, m_need_e, m_ticks;
    bit [1:0] m_cause;
    bit       m_done;

    task automatic model_reset();
        m_prev = '1; m_seen = '0; m_phase = 0; m_got = 0; m_ticks = 0;
        m_need_s = 1; m_need_e = 1; m_cause = 2'b00; m_done = 1'b0;
    endtask

    function automatic bit m_match(bit [3:0] r, bit [3:0] mask, bit all_mode);
        if (mask == 4'b0) return 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (all_mode && mask[i] && !(m_seen[i] || r[i])) return 1'b0;
            if (!all_mode && mask[i] && r[i]) return 1'b1;
        end
        return all_mode;
    endfunction

    task automatic model_step();
        bit [3:0] r;
        int       old;
        if (!reset_n) begin
            model_reset();
            return;
        end
        r      = evt_in & ~m_prev;
        m_prev = evt_in;
        old    = m_phase;
        if (m_phase != 0 && abort) begin
            m_phase = 0; m_cause = 2'b11;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_need_s = int'(start_num) + 1; m_need_e = int'(stop_num) + 1;
                    m_got = 0; m_ticks = 0; m_cause = 2'b00; m_seen = '0;
                    m_phase = gate_en ? 1 : 2;
                end
                1: if (arm_gate) begin m_phase = 2; m_seen = '0; end
                2: if (m_match(r, start_mask, start_all)) begin
                    m_got++; m_seen = '0;
                    if (m_got == m_need_s) begin m_phase = 3; m_got = 0; end
                end else begin
                    if (start_all) m_seen |= r & start_mask;
                    if (tick && timeout != 0) begin
                        m_ticks++;
                        if (m_ticks == int'(timeout)) begin m_phase = 0; m_cause = 2'b10; end
                    end
                end
                default: if (mem_full) begin
                    m_phase = 0; m_cause = 2'b01;
                end else if (m_match(r, stop_mask, stop_all)) begin
                    m_got++; m_seen = '0;
                    if (m_got == m_need_e) begin m_phase = 0; m_cause = 2'b00; end
                end else if (stop_all) begin
                    m_seen |= r & stop_mask;
                end
            endcase
        end
        m_done = (old != 0) && (m_phase == 0);
    endtask

    function automatic logic [4:0] model_exp();
        return {(m_phase == 1 || m_phase == 2), (m_phase == 3), m_done, m_cause};
    endfunction

    task automatic check(input string name, input logic [4:0] exp);
        logic [4:0] got;
        got = {waiting, acquiring, done, stop_cause};
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got {wait,acq,done,cause}=%b, expected %b at %0t",
                      name, got, exp, $time);
    endtask

    task automatic step_cycle();
        @(posedge clk_master);
        model_step();
        #1;
        if (chk_model) check("model", model_exp());
    endtask

    typedef struct {
        logic       start;
        logic [3:0] evt;
        logic [4:0] exp;  // {waiting, acquiring, done, stop_cause}
    } vec_t;
    vec_t vecs[9];

    initial begin
        vecs[0] = '{1'b1, 4'h0, 5'b10000};
        vecs[1] = '{1'b0, 4'h1, 5'b10000};
        vecs[2] = '{1'b0, 4'h0, 5'b10000};
        vecs[3] = '{1'b0, 4'h1, 5'b10000};
        vecs[4] = '{1'b0, 4'h0, 5'b10000};
        vecs[5] = '{1'b0, 4'h1, 5'b01000};
        vecs[6] = '{1'b0, 4'h0, 5'b01000};
        vecs[7] = '{1'b0, 4'h1, 5'b00100};
        vecs[8] = '{1'b0, 4'h0, 5'b00000};

        reset_n = 1'b0; start = 0; abort = 0; start_all = 0; stop_all = 0; gate_en = 0;
        arm_gate = 0; mem_full = 0; tick = 0; evt_in = 4'h0; start_mask = 4'h1;
        stop_mask = 4'h1; start_num = 8'd2; stop_num = 8'd0; timeout = 16'd0;
        model_reset();
        step_cycle();
        step_cycle();
        check("reset_state", 5'b00000);
        reset_n = 1'b1;

        // Basic count: three start rises to acquire, one stop rise to finish.
        for (int i = 0; i < 9; i++) begin
            start  = vecs[i].start;
            evt_in = vecs[i].evt;
            step_cycle();
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // All-of start mode.
        start_all = 1; start_mask = 4'b0110; start_num = 0;
        start = 1; step_cycle(); start = 0;
        check("all_start", 5'b10000);
        evt_in = 4'b0010; step_cycle(); check("all_first_only", 5'b10000);
        evt_in = 4'b0000; repeat (4) step_cycle(); check("all_still_wait", 5'b10000);
        evt_in = 4'b0100; step_cycle(); check("all_complete", 5'b01000);
        evt_in = 4'b0000; abort = 1; step_cycle(); check("abort_acq", 5'b00111);
        abort = 0; step_cycle(); check("abort_done_clear", 5'b00011);
        start = 1; step_cycle(); start = 0;
        evt_in = 4'b0010; step_cycle(); evt_in = 4'b0000; step_cycle();
        evt_in = 4'b0010; step_cycle(); evt_in = 4'b0000; step_cycle();
        check("all_same_evt_twice", 5'b10000);
        abort = 1; step_cycle(); abort = 0; step_cycle();

        // Arm gate.
        start_all = 0; gate_en = 1; start_mask = 4'b0001;
        start = 1; step_cycle(); start = 0; check("gate_entered", 5'b10000);
        evt_in = 4'b0001; step_cycle(); check("gate_evt_ignored", 5'b10000);
        evt_in = 4'b0000; step_cycle();
        arm_gate = 1; step_cycle(); arm_gate = 0; check("gate_armed", 5'b10000);
        evt_in = 4'b0001; step_cycle(); check("gate_acq", 5'b01000);
        evt_in = 4'b0000; abort = 1; step_cycle(); abort = 0; gate_en = 0; step_cycle();

        // Start-wait timeout.
        timeout = 16'd3;
        start = 1; step_cycle(); start = 0;
        for (int i = 1; i <= 30; i++) begin
            tick = (i % 10 == 0);
            step_cycle();
            if (i == 29) check("tmo_before", 5'b10000);
            if (i == 30) check("tmo_fire", 5'b00110);
        end
        tick = 0; step_cycle(); check("tmo_done_clear", 5'b00010);
        timeout = 16'd0;
        start = 1; step_cycle(); start = 0;
        for (int i = 1; i <= 40; i++) begin
            tick = (i % 10 == 0);
            step_cycle();
        end
        tick = 0; check("tmo_disabled", 5'b10000);
        abort = 1; step_cycle(); abort = 0; step_cycle();

        // Empty start mask, mem_full beating a stop event.
        start_mask = 4'b0000; start_num = 0; stop_mask = 4'b0001; stop_num = 0;
        start = 1; step_cycle(); start = 0; step_cycle(); check("mask0_acq", 5'b01000);
        evt_in = 4'b0001; mem_full = 1; step_cycle(); check("memfull_prio", 5'b00101);
        evt_in = 4'b0000; mem_full = 0; step_cycle();

        // Empty stop mask ends after STOP_NUM+1 cycles.
        stop_mask = 4'b0000; stop_num = 8'd2;
        start = 1; step_cycle(); start = 0; step_cycle(); check("stop0_acq", 5'b01000);
        step_cycle(); step_cycle(); check("stop0_hold", 5'b01000);
        step_cycle(); check("stop0_end", 5'b00100);

        // Abort beats start; abort in idle is inert.
        start_mask = 4'b0001; stop_mask = 4'b0001; stop_num = 0;
        start = 1; step_cycle(); check("abort_prep", 5'b10000);
        abort = 1; step_cycle(); check("abort_start", 5'b00111);
        abort = 0; start = 0; step_cycle(); check("abort_single_done", 5'b00011);
        abort = 1; step_cycle(); abort = 0; check("abort_idle", 5'b00011);

        // Event held high through reset is not an event.
        evt_in = 4'b0001; reset_n = 0; step_cycle(); reset_n = 1;
        start = 1; step_cycle(); start = 0; check("held_start", 5'b10000);
        repeat (3) step_cycle(); check("held_high_ignored", 5'b10000);
        evt_in = 4'b0000; step_cycle(); evt_in = 4'b0001; step_cycle();
        check("rearmed_event", 5'b01000);
        reset_n = 0; #1; check("reset_midop", 5'b00000);
        step_cycle(); reset_n = 1; step_cycle(); check("no_done_after_reset", 5'b00000);

        // Random stimulus against the model.
        evt_in = 4'b0000; reset_n = 0; step_cycle(); reset_n = 1;
        chk_model = 1'b1;
        for (int ep = 0; ep < 40; ep++) begin
            start_mask = 4'($urandom_range(0, 15)); stop_mask = 4'($urandom_range(0, 15));
            start_all  = 1'($urandom_range(0, 1));  stop_all  = 1'($urandom_range(0, 1));
            start_num  = 8'($urandom_range(0, 3));  stop_num  = 8'($urandom_range(0, 3));
            gate_en    = ($urandom_range(0, 3) == 0);
            timeout    = 16'($urandom_range(0, 5));
            for (int c = 0; c < 60; c++) begin
                start    = ($urandom_range(0, 3) == 0);
                abort    = ($urandom_range(0, 63) == 0);
                mem_full = ($urandom_range(0, 31) == 0);
                tick     = ($urandom_range(0, 3) == 0);
                arm_gate = ($urandom_range(0, 7) == 0);
                for (int b = 0; b < 4; b++)
                    if ($urandom_range(0, 3) == 0) evt_in[b] = ~evt_in[b];
                step_cycle();
            end
        end
        chk_model = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
